// File: rtl/imem_loader_ctrl.sv
// Instruction-memory loader controller.
// In RUN the CPU fetches straight through to the instruction memory.
// When a load starts, the CPU is stalled. The block then assembles
// big-endian 16-bit words from the incoming byte stream and writes each
// word to consecutive memory addresses, starting at address 0.
module imem_loader_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_start,
    input  logic [8:0]  ld_len,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic [7:0]  cpu_addr,
    output logic [15:0] cpu_instr,
    output logic        cpu_stall,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        ld_done,
    output logic [8:0]  wr_count
);

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_LOAD_HI = 3'd1;
    localparam logic [2:0] ST_LOAD_LO = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // A word count can never exceed the 256-entry memory.
    localparam logic [8:0] MAX_LEN = 9'd256;

    logic [2:0] state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [8:0] wr_count_q, wr_count_d;
    logic [8:0] len_q, len_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;
    logic [8:0] wr_count_inc;

    assign wr_count_inc = wr_count_q + 9'd1;

    // Next-state logic: FSM sequencing, byte capture and write bookkeeping.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wr_count_d = wr_count_q;
        len_d      = len_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            ST_RUN: begin
                if (ld_start) begin
                    len_d      = (ld_len > MAX_LEN) ? MAX_LEN : ld_len;
                    ptr_d      = 8'd0;
                    wr_count_d = 9'd0;
                    state_d    = (ld_len == 9'd0) ? ST_DONE : ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                if (ld_valid) begin
                    hi_d    = ld_data;
                    state_d = ST_LOAD_LO;
                end
            end
            ST_LOAD_LO: begin
                if (ld_valid) begin
                    lo_d    = ld_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The pointer wraps naturally at 8 bits. The count is
                // 9 bits wide so that it can reach 256.
                ptr_d      = ptr_q + 8'd1;
                wr_count_d = wr_count_inc;
                state_d    = (wr_count_inc == len_q) ? ST_DONE : ST_LOAD_HI;
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            ptr_q      <= 8'd0;
            wr_count_q <= 9'd0;
            len_q      <= 9'd0;
            hi_q       <= 8'd0;
            lo_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wr_count_q <= wr_count_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Output decode. In RUN the memory is passed through; otherwise the
    // CPU is stalled, sees a NOP, and the memory address follows ptr.
    always_comb begin
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        cpu_stall = 1'b1;
        busy      = 1'b1;
        ld_done   = 1'b0;
        cpu_instr = 16'h0000;
        mem_addr  = ptr_q;
        mem_wdata = {hi_q, lo_q};
        case (state_q)
            ST_RUN: begin
                cpu_stall = 1'b0;
                busy      = 1'b0;
                cpu_instr = mem_rdata;
                mem_addr  = cpu_addr;
            end
            ST_LOAD_HI, ST_LOAD_LO: begin
                ld_ready = 1'b1;
            end
            ST_WRITE: begin
                mem_we = 1'b1;
            end
            ST_DONE: begin
                ld_done = 1'b1;
            end
            default: begin
                ld_ready = 1'b0;
            end
        endcase
    end

    assign wr_count = wr_count_q;

endmodule
